// File: rtl/dcache_fill_if.sv
// MEM-stage miss / main-memory / data-array signal bundle for the D-cache fill engine.
// The fill engine is the slave; the pipeline/memory side (or a bench) is the master.
interface dcache_fill_if #(
  parameter int ADDR_W          = 16,
  parameter int WORDS_PER_BLOCK = 8
);
  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);

  logic              miss_detected;
  logic [ADDR_W-1:0] miss_address;
  logic              memory_data_valid;
  logic [15:0]       memory_data;
  logic              memory_read;
  logic [ADDR_W-1:0] memory_address;
  logic              fsm_busy;
  logic              write_data_array;
  logic [IDX_W-1:0]  fill_word_idx;
  logic [15:0]       fill_data;
  logic              write_tag_array;
  logic              fill_done;

  modport slave (
    input  miss_detected, miss_address, memory_data_valid, memory_data,
    output memory_read, memory_address, fsm_busy, write_data_array,
           fill_word_idx, fill_data, write_tag_array, fill_done
  );

  modport master (
    output miss_detected, miss_address, memory_data_valid, memory_data,
    input  memory_read, memory_address, fsm_busy, write_data_array,
           fill_word_idx, fill_data, write_tag_array, fill_done
  );
endinterface

// File: rtl/dcache_fill_fsm.sv
// D-cache block fill engine: issues one pipelined read per cycle for the missing block,
// streams returned words into the data array and writes the tag with the last word.
module dcache_fill_fsm #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int ADDR_W          = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  dcache_fill_if.slave  bus
);
  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((2 * WORDS_PER_BLOCK) - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [CNT_W-1:0]  req_q, req_d;
  logic [CNT_W-1:0]  rcv_q, rcv_d;
  logic              done_q, done_d;
  logic [IDX_W-1:0]  off_s;

  logic              memory_read_s;
  logic [ADDR_W-1:0] memory_address_s;
  logic              fsm_busy_s;
  logic              write_data_array_s;
  logic [IDX_W-1:0]  fill_word_idx_s;
  logic [15:0]       fill_data_s;
  logic              write_tag_array_s;

  // State and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= {ADDR_W{1'b0}};
      req_q   <= {CNT_W{1'b0}};
      rcv_q   <= {CNT_W{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      req_q   <= req_d;
      rcv_q   <= rcv_d;
      done_q  <= done_d;
    end
  end

  // Once all requests are out the address parks on the last word of the block
  assign off_s = (req_q < CNT_W'(WORDS_PER_BLOCK)) ? req_q[IDX_W-1:0]
                                                   : IDX_W'(WORDS_PER_BLOCK - 1);

  // Next-state, request side and receive side
  always_comb begin
    state_d            = state_q;
    base_d             = base_q;
    req_d              = req_q;
    rcv_d              = rcv_q;
    done_d             = 1'b0;
    memory_read_s      = 1'b0;
    memory_address_s   = {ADDR_W{1'b0}};
    fsm_busy_s         = 1'b0;
    write_data_array_s = 1'b0;
    fill_word_idx_s    = {IDX_W{1'b0}};
    fill_data_s        = 16'h0000;
    write_tag_array_s  = 1'b0;

    case (state_q)
      IDLE: begin
        fsm_busy_s = bus.miss_detected;
        if (bus.miss_detected) begin
          base_d  = bus.miss_address & ~OFF_MASK;
          req_d   = {CNT_W{1'b0}};
          rcv_d   = {CNT_W{1'b0}};
          state_d = FILL;
        end else begin
          state_d = IDLE;
        end
      end
      FILL: begin
        fsm_busy_s       = 1'b1;
        memory_address_s = base_q + ADDR_W'({off_s, 1'b0});
        if (req_q < CNT_W'(WORDS_PER_BLOCK)) begin
          memory_read_s = 1'b1;
          req_d         = req_q + CNT_W'(1);
        end else begin
          req_d = req_q;
        end
        if (bus.memory_data_valid) begin
          write_data_array_s = 1'b1;
          fill_word_idx_s    = rcv_q[IDX_W-1:0];
          fill_data_s        = bus.memory_data;
          rcv_d              = rcv_q + CNT_W'(1);
          if (rcv_q == CNT_W'(WORDS_PER_BLOCK - 1)) begin
            write_tag_array_s = 1'b1;
            done_d            = 1'b1;
            state_d           = IDLE;
          end else begin
            state_d = FILL;
          end
        end else begin
          rcv_d = rcv_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.memory_read      = memory_read_s;
  assign bus.memory_address   = memory_address_s;
  assign bus.fsm_busy         = fsm_busy_s;
  assign bus.write_data_array = write_data_array_s;
  assign bus.fill_word_idx    = fill_word_idx_s;
  assign bus.fill_data        = fill_data_s;
  assign bus.write_tag_array  = write_tag_array_s;
  assign bus.fill_done        = done_q;
endmodule

// File: tb/tb_dcache_fill_fsm.sv
// Directed bench for dcache_fill_fsm with a 4-cycle pipelined memory model
// that returns (address ^ 16'hA5A5) for each request.
module tb_dcache_fill_fsm;
  logic clk;
  logic rst_n;
  int   passed;
  int   total;
  bit   mem_auto;
  logic        sv [0:4];
  logic [15:0] sd [0:4];

  dcache_fill_if #(.ADDR_W(16), .WORDS_PER_BLOCK(8)) bus ();

  dcache_fill_fsm #(.WORDS_PER_BLOCK(8), .ADDR_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {read, addr, wr, idx, data, tag, done, busy}
  function automatic logic [39:0] dut_vec();
    return {bus.memory_read, bus.memory_address, bus.write_data_array, bus.fill_word_idx,
            bus.fill_data, bus.write_tag_array, bus.fill_done, bus.fsm_busy};
  endfunction

  // Expected outputs c cycles after the miss, with the auto memory model
  function automatic logic [39:0] fill_vec(input int c, input logic [15:0] base);
    logic        rd, wr, tag, done, busy;
    logic [15:0] a, d;
    logic [2:0]  idx;
    rd = 1'b0; wr = 1'b0; tag = 1'b0; done = 1'b0; busy = 1'b0;
    a = 16'h0000; d = 16'h0000; idx = 3'd0;
    if (c >= 1 && c <= 12) begin
      busy = 1'b1;
      rd   = (c <= 8);
      a    = base + 16'(2 * ((c <= 8) ? (c - 1) : 7));
    end
    if (c >= 5 && c <= 12) begin
      wr  = 1'b1;
      idx = 3'(c - 5);
      d   = (base + 16'(2 * (c - 5))) ^ 16'hA5A5;
    end
    tag  = (c == 12);
    done = (c == 13);
    return {rd, a, wr, idx, d, tag, done, busy};
  endfunction

  task automatic next_cycle();
    if (mem_auto && bus.memory_read === 1'b1) begin
      sv[4] = 1'b1;
      sd[4] = bus.memory_address ^ 16'hA5A5;
    end
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      sv[i] = sv[i+1];
      sd[i] = sd[i+1];
    end
    sv[4] = 1'b0;
    sd[4] = 16'h0000;
    @(negedge clk);
    if (mem_auto) begin
      bus.memory_data_valid = sv[0];
      bus.memory_data       = sv[0] ? sd[0] : 16'h0000;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) next_cycle();
    total++;
    if (dut_vec() !== 40'h0) $display("FAIL reset_hold got %h exp %h", dut_vec(), 40'h0);
    else passed++;
    rst_n = 1'b1;
    next_cycle();
    total++;
    if (dut_vec() !== 40'h0) $display("FAIL reset_idle got %h exp %h", dut_vec(), 40'h0);
    else passed++;
  endtask

  task automatic test_basic_fill();
    bus.miss_detected = 1'b1;
    bus.miss_address  = 16'h1236;
    #1;
    total++;
    if (dut_vec() !== 40'h1) $display("FAIL basic_miss_cycle got %h exp %h", dut_vec(), 40'h1);
    else passed++;
    next_cycle();
    bus.miss_detected = 1'b0;
    bus.miss_address  = 16'h0000;
    #1;
    for (int c = 1; c <= 13; c++) begin
      total++;
      if (dut_vec() !== fill_vec(c, 16'h1230))
        $display("FAIL basic c=%0d got %h exp %h", c, dut_vec(), fill_vec(c, 16'h1230));
      else passed++;
      next_cycle();
    end
  endtask

  task automatic test_wrap();
    bus.miss_detected = 1'b1;
    bus.miss_address  = 16'hFFFA;
    #1;
    next_cycle();
    bus.miss_detected = 1'b0;
    #1;
    for (int c = 1; c <= 13; c++) begin
      total++;
      if (dut_vec() !== fill_vec(c, 16'hFFF0))
        $display("FAIL wrap c=%0d got %h exp %h", c, dut_vec(), fill_vec(c, 16'hFFF0));
      else passed++;
      next_cycle();
    end
  endtask

  task automatic test_miss_ignored();
    bus.miss_detected = 1'b1;
    bus.miss_address  = 16'h0A10;
    #1;
    next_cycle();
    for (int c = 1; c <= 13; c++) begin
      bus.miss_detected = (c >= 2 && c <= 6);
      bus.miss_address  = (c >= 2 && c <= 6) ? 16'h4000 : 16'h0000;
      #1;
      total++;
      if (dut_vec() !== fill_vec(c, 16'h0A10))
        $display("FAIL ignore c=%0d got %h exp %h", c, dut_vec(), fill_vec(c, 16'h0A10));
      else passed++;
      next_cycle();
    end
    total++;
    if (dut_vec() !== 40'h0) $display("FAIL ignore_no_refill got %h exp %h", dut_vec(), 40'h0);
    else passed++;
  endtask

  task automatic test_gapped_valid();
    logic [39:0] e;
    logic        v;
    int          k;
    mem_auto = 1'b0;
    bus.memory_data_valid = 1'b0;
    bus.memory_data       = 16'h0000;
    bus.miss_detected = 1'b1;
    bus.miss_address  = 16'h2000;
    #1;
    next_cycle();
    bus.miss_detected = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      v = (c >= 5 && c <= 19 && ((c - 5) % 2 == 0));
      k = (c - 5) / 2;
      bus.memory_data_valid = v;
      bus.memory_data       = v ? 16'(16'h1000 + k) : 16'h0000;
      #1;
      e = 40'h0;
      if (c <= 19) begin
        e[0]     = 1'b1;
        e[39]    = (c <= 8);
        e[38:23] = 16'h2000 + 16'(2 * ((c <= 8) ? (c - 1) : 7));
      end
      if (v) begin
        e[22]    = 1'b1;
        e[21:19] = 3'(k);
        e[18:3]  = 16'(16'h1000 + k);
      end
      e[2] = (c == 19);
      e[1] = (c == 20);
      total++;
      if (dut_vec() !== e) $display("FAIL gapped c=%0d got %h exp %h", c, dut_vec(), e);
      else passed++;
      next_cycle();
    end
    bus.memory_data_valid = 1'b0;
    mem_auto = 1'b1;
  endtask

  task automatic test_reset_midfill();
    bus.miss_detected = 1'b1;
    bus.miss_address  = 16'h3000;
    #1;
    next_cycle();
    bus.miss_detected = 1'b0;
    #1;
    for (int c = 1; c <= 7; c++) begin
      total++;
      if (dut_vec() !== fill_vec(c, 16'h3000))
        $display("FAIL midrst_pre c=%0d got %h exp %h", c, dut_vec(), fill_vec(c, 16'h3000));
      else passed++;
      next_cycle();
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (dut_vec() !== 40'h0) $display("FAIL midrst_async got %h exp %h", dut_vec(), 40'h0);
    else passed++;
    next_cycle();
    rst_n = 1'b1;
    #1;
    // Stale returns from the abandoned fill land while idle and must be dropped
    for (int c = 0; c < 5; c++) begin
      total++;
      if (dut_vec() !== 40'h0) $display("FAIL midrst_stale c=%0d got %h exp %h", c, dut_vec(), 40'h0);
      else passed++;
      next_cycle();
    end
    bus.miss_detected = 1'b1;
    bus.miss_address  = 16'h0040;
    #1;
    next_cycle();
    bus.miss_detected = 1'b0;
    #1;
    for (int c = 1; c <= 13; c++) begin
      total++;
      if (dut_vec() !== fill_vec(c, 16'h0040))
        $display("FAIL midrst_refill c=%0d got %h exp %h", c, dut_vec(), fill_vec(c, 16'h0040));
      else passed++;
      next_cycle();
    end
  endtask

  initial begin
    passed   = 0;
    total    = 0;
    mem_auto = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sv[i] = 1'b0;
      sd[i] = 16'h0000;
    end
    rst_n                 = 1'b0;
    bus.miss_detected     = 1'b0;
    bus.miss_address      = 16'h0000;
    bus.memory_data_valid = 1'b0;
    bus.memory_data       = 16'h0000;
    test_reset();
    test_basic_fill();
    test_wrap();
    test_miss_ignored();
    test_gapped_valid();
    test_reset_midfill();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
